conv_layer_seq: RTL

Time-multiplexed, parametrised convolution layer: accepts one receptive-field window (KERNEL_SIZE × IN_CH signed 8-bit pixels) per transaction and evaluates it against NUM_FILTERS locally stored filters. It reuses LANES multipliers sequentially instead of instantiating one engine per filter. Per filter, the block adds a bias, applies an arithmetic shift, optional ReLU and signed 8-bit saturation, then returns the packed filter results on a valid/ready output. It replaces the fully parallel conv layer wherever area matters more than throughput.

---
 rtl/conv_layer_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/conv_layer_seq.sv
// Sequential convolution layer: one receptive-field window against NUM_FILTERS
// stored filters, LANES multipliers reused per MAC cycle.
module conv_layer_seq #(
    parameter int KERNEL_SIZE = 9,
    parameter int IN_CH       = 3,
    parameter int NUM_FILTERS = 16,
    parameter int LANES       = 9,
    parameter int ACC_W       = 24,
    parameter int BIAS_W      = 16,
    parameter int SHIFT       = 0,
    parameter int RELU_EN     = 1,
    localparam int NE         = KERNEL_SIZE * IN_CH,
    localparam int AW         = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NE*8-1:0]            in_data,
    input  logic                       wt_we,
    output logic                       wt_ready,
    input  logic [AW-1:0]              wt_addr,
    input  logic [NE*8-1:0]            wt_data,
    input  logic [BIAS_W-1:0]          wt_bias,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_FILTERS*8-1:0]   out_data,
    output logic                       busy
);

    localparam int STEPS = NE / LANES;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] MINV = -ACC_W'(128);

    typedef enum logic [1:0] {IDLE, MAC, POST, OUT} state_t;

    state_t state, state_nxt;

    logic [NE*8-1:0]          win;
    logic [NE*8-1:0]          wts  [NUM_FILTERS];
    logic [BIAS_W-1:0]        bias [NUM_FILTERS];
    logic signed [ACC_W-1:0]  acc;
    logic [SW-1:0]            step;
    logic [AW-1:0]            filt;

    logic                     addr_ok;
    logic                     wr_en;
    logic                     last_step;
    logic                     last_filt;
    logic signed [ACC_W-1:0]  mac_sum;
    logic signed [ACC_W-1:0]  biased;
    logic signed [ACC_W-1:0]  shifted;
    logic [7:0]               res;

    generate
        if ((1 << AW) == NUM_FILTERS) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_chk
            assign addr_ok = ({1'b0, wt_addr} < (AW+1)'(NUM_FILTERS));
        end
    endgenerate

    assign in_ready  = (state == IDLE);
    assign wt_ready  = (state == IDLE);
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);

    assign wr_en     = wt_we && addr_ok && (state == IDLE);
    assign last_step = (step == SW'(STEPS - 1));
    assign last_filt = (filt == AW'(NUM_FILTERS - 1));

    always_comb begin
        logic signed [7:0]  a;
        logic signed [7:0]  b;
        logic signed [15:0] p;
        int                 idx;
        mac_sum = '0;
        a       = '0;
        b       = '0;
        p       = '0;
        idx     = 0;
        for (int l = 0; l < LANES; l++) begin
            idx     = int'(step) * LANES + l;
            a       = win[idx*8 +: 8];
            b       = wts[filt][idx*8 +: 8];
            p       = a * b;
            mac_sum = mac_sum + {{(ACC_W-16){p[15]}}, p};
        end
    end

    always_comb begin
        biased  = acc + {{(ACC_W-BIAS_W){bias[filt][BIAS_W-1]}}, bias[filt]};
        shifted = biased >>> SHIFT;
        if (RELU_EN != 0 && shifted[ACC_W-1])
            res = 8'h00;
        else if (shifted > MAXV)
            res = 8'h7f;
        else if (shifted < MINV)
            res = 8'h80;
        else
            res = shifted[7:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = MAC;
            MAC:  if (last_step) state_nxt = POST;
            POST: state_nxt = last_filt ? OUT : MAC;
            OUT:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win      <= '0;
            acc      <= '0;
            step     <= '0;
            filt     <= '0;
            out_data <= '0;
            for (int f = 0; f < NUM_FILTERS; f++) begin
                wts[f]  <= '0;
                bias[f] <= '0;
            end
        end else begin
            if (wr_en) begin
                wts[wt_addr]  <= wt_data;
                bias[wt_addr] <= wt_bias;
            end
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        win  <= in_data;
                        acc  <= '0;
                        step <= '0;
                        filt <= '0;
                    end
                end
                MAC: begin
                    acc  <= acc + mac_sum;
                    step <= step + 1'b1;
                end
                POST: begin
                    // filter 0 lands in the most significant byte
                    out_data[(NUM_FILTERS-1-int'(filt))*8 +: 8] <= res;
                    acc  <= '0;
                    step <= '0;
                    if (!last_filt) filt <= filt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
